// File: rtl/lc3_program_loader.sv
// rtl/lc3_program_loader.sv - LC-3 object image byte-stream loader into instruction RAM
//
// Takes a big-endian byte stream (origin word, then data words) and writes each
// data word into instruction RAM at consecutive addresses starting at the origin.
// The CPU is held off instruction memory while a load is running.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               one-cycle pulse; begins a load from IDLE or DONE
//   s_data/s_valid/s_last/s_ready   byte stream input
//   mem_we/mem_addr/mem_wdata       instruction RAM write port
//   cpu_hold            high while a load is in progress
//   load_done           high once the image has ended (DONE)
//   origin, word_count  origin word and number of data words consumed
//   err_overflow        a word addressed at or above 2^ADDR_W was dropped
//   err_odd             image ended on a high byte
module lc3_program_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [15:0]       origin,
    output logic [15:0]       word_count,
    output logic              err_overflow,
    output logic              err_odd
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ORG_HI = 3'd1,
        ST_ORG_LO = 3'd2,
        ST_DAT_HI = 3'd3,
        ST_DAT_LO = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  hi_byte;
    logic [15:0] addr_cnt;
    logic        accept;
    logic        start_ok;
    logic        addr_oob;

    // s_ready, cpu_hold and load_done are pure decodes of the state register,
    // so nothing combinational runs from s_valid back to s_ready.
    assign s_ready   = (state == ST_ORG_HI) || (state == ST_ORG_LO) ||
                       (state == ST_DAT_HI) || (state == ST_DAT_LO);
    assign cpu_hold  = s_ready;
    assign load_done = (state == ST_DONE);

    assign accept   = s_valid && s_ready;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    // Any set bit above the RAM address range means the word has nowhere to go.
    // Widening first keeps the shift well defined when ADDR_W is 16.
    assign addr_oob = (({16'd0, addr_cnt} >> ADDR_W) != 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = ST_ORG_HI;
            end
            ST_ORG_HI: begin
                if (accept) state_next = s_last ? ST_DONE : ST_ORG_LO;
            end
            ST_ORG_LO: begin
                if (accept) state_next = s_last ? ST_DONE : ST_DAT_HI;
            end
            ST_DAT_HI: begin
                if (accept) state_next = s_last ? ST_DONE : ST_DAT_LO;
            end
            ST_DAT_LO: begin
                if (accept) state_next = s_last ? ST_DONE : ST_DAT_HI;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_byte      <= 8'd0;
            addr_cnt     <= 16'd0;
            origin       <= 16'd0;
            word_count   <= 16'd0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 16'd0;
            err_overflow <= 1'b0;
            err_odd      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                origin       <= 16'd0;
                word_count   <= 16'd0;
                err_overflow <= 1'b0;
                err_odd      <= 1'b0;
            end
            if (accept) begin
                case (state)
                    ST_ORG_HI, ST_DAT_HI: begin
                        // A last byte landing on a high half cannot form a word.
                        if (s_last) begin
                            err_odd <= 1'b1;
                        end else begin
                            hi_byte <= s_data;
                        end
                    end
                    ST_ORG_LO: begin
                        origin   <= {hi_byte, s_data};
                        addr_cnt <= {hi_byte, s_data};
                    end
                    ST_DAT_LO: begin
                        if (addr_oob) begin
                            err_overflow <= 1'b1;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_cnt[ADDR_W-1:0];
                            mem_wdata <= {hi_byte, s_data};
                        end
                        addr_cnt   <= addr_cnt + 16'd1;
                        word_count <= word_count + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lc3_program_loader.sv
// tb/tb_lc3_program_loader.sv - directed bench for lc3_program_loader (ADDR_W 16 and 10)
module tb_lc3_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;

    logic        s_ready_a, mem_we_a, cpu_hold_a, load_done_a, err_ovf_a, err_odd_a;
    logic [15:0] mem_addr_a, mem_wdata_a, origin_a, word_count_a;

    logic        s_ready_b, mem_we_b, cpu_hold_b, load_done_b, err_ovf_b, err_odd_b;
    logic [9:0]  mem_addr_b;
    logic [15:0] mem_wdata_b, origin_b, word_count_b;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] wa_a[$], wd_a[$], wa_b[$], wd_b[$];

    always #5 clk = ~clk;

    lc3_program_loader #(.ADDR_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready_a),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .cpu_hold(cpu_hold_a), .load_done(load_done_a), .origin(origin_a),
        .word_count(word_count_a), .err_overflow(err_ovf_a), .err_odd(err_odd_a)
    );

    lc3_program_loader #(.ADDR_W(10)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .cpu_hold(cpu_hold_b), .load_done(load_done_b), .origin(origin_b),
        .word_count(word_count_b), .err_overflow(err_ovf_b), .err_odd(err_odd_b)
    );

    always @(negedge clk) begin
        if (mem_we_a) begin
            wa_a.push_back(mem_addr_a);
            wd_a.push_back(mem_wdata_a);
        end
        if (mem_we_b) begin
            wa_b.push_back({6'd0, mem_addr_b});
            wd_b.push_back(mem_wdata_b);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa_a.delete(); wd_a.delete(); wa_b.delete(); wd_b.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte and hold it until the loader takes it, then idle for gap cycles.
    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        bit took = 0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        for (int i = 0; i < 20 && !took; i++) begin
            if (s_ready_a) took = 1;
            tick();
        end
        if (!took) check("accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic send_image(input logic [7:0] img[], input int gap);
        for (int i = 0; i < img.size(); i++)
            send_byte(img[i], (i == img.size() - 1), (i == img.size() - 1) ? 0 : gap);
    endtask

    task automatic check_scen1(input string p);
        check({p, "_nwr"},   wa_a.size(), 2);
        if (wa_a.size() == 2) begin
            check({p, "_a0"}, wa_a[0], 16'h3000);
            check({p, "_d0"}, wd_a[0], 16'hE002);
            check({p, "_a1"}, wa_a[1], 16'h3001);
            check({p, "_d1"}, wd_a[1], 16'hF025);
        end
        check({p, "_origin"}, origin_a, 16'h3000);
        check({p, "_wcnt"},   word_count_a, 16'd2);
    endtask

    logic [7:0] img1[] = '{8'h30, 8'h00, 8'hE0, 8'h02, 8'hF0, 8'h25};
    logic [7:0] img3[] = '{8'hFF, 8'hFF, 8'h11, 8'h11, 8'h22, 8'h22};
    logic [7:0] img4[] = '{8'h03, 8'hFF, 8'hAA, 8'hAA, 8'hBB, 8'hBB};
    logic [7:0] img5[] = '{8'h40, 8'h00, 8'h12, 8'h34, 8'h56};
    logic [7:0] img6[] = '{8'h12};

    initial begin
        reset = 1'b1; start = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_s_ready",   s_ready_a, 0);
        check("rst_mem_we",    mem_we_a, 0);
        check("rst_mem_addr",  mem_addr_a, 0);
        check("rst_mem_wdata", mem_wdata_a, 0);
        check("rst_cpu_hold",  cpu_hold_a, 0);
        check("rst_load_done", load_done_a, 0);
        check("rst_origin",    origin_a, 0);
        check("rst_wcnt",      word_count_a, 0);
        check("rst_errs",      {err_ovf_a, err_odd_a}, 0);

        // s_last with s_valid low in IDLE does nothing
        s_last = 1'b1; tick(); s_last = 1'b0;
        check("idle_last_noop", {s_ready_a, load_done_a, err_odd_a}, 0);

        // 1: back-to-back image
        clear_log();
        pulse_start();
        check("s1_ready_after_start", s_ready_a, 1);
        check("s1_hold_after_start",  cpu_hold_a, 1);
        send_image(img1, 0);
        check("s1_final_we",    mem_we_a, 1);
        check("s1_final_addr",  mem_addr_a, 16'h3001);
        check("s1_done",        load_done_a, 1);
        check("s1_hold_low",    cpu_hold_a, 0);
        check("s1_ready_low",   s_ready_a, 0);
        tick();
        check("s1_we_drop",     mem_we_a, 0);
        check("s1_addr_hold",   mem_addr_a, 16'h3001);
        check_scen1("s1");

        // 2: gaps of 3 idle cycles
        clear_log();
        pulse_start();
        check("s2_cleared", {origin_a, word_count_a}, 0);
        check("s2_done_clr", load_done_a, 0);
        send_image(img1, 3);
        tick();
        check_scen1("s2");

        // 3: address wrap at 0xFFFF
        clear_log();
        pulse_start();
        send_image(img3, 0);
        tick();
        check("s3_nwr", wa_a.size(), 2);
        if (wa_a.size() == 2) begin
            check("s3_a0", wa_a[0], 16'hFFFF);
            check("s3_d0", wd_a[0], 16'h1111);
            check("s3_a1", wa_a[1], 16'h0000);
            check("s3_d1", wd_a[1], 16'h2222);
        end
        check("s3_ovf", err_ovf_a, 0);

        // 4: overflow past 2^10 on the narrow instance
        clear_log();
        pulse_start();
        send_image(img4, 0);
        tick();
        check("s4_nwr", wa_b.size(), 1);
        if (wa_b.size() == 1) begin
            check("s4_a0", wa_b[0], 16'h03FF);
            check("s4_d0", wd_b[0], 16'hAAAA);
        end
        check("s4_ovf",      err_ovf_b, 1);
        check("s4_wcnt",     word_count_b, 2);
        check("s4_wide_ovf", err_ovf_a, 0);
        check("s4_wide_nwr", wa_a.size(), 2);

        // 5: odd-length image
        clear_log();
        pulse_start();
        check("s5_ovf_clr", err_ovf_b, 0);
        send_image(img5, 0);
        check("s5_no_we", mem_we_a, 0);
        check("s5_done",  load_done_a, 1);
        tick();
        check("s5_nwr", wa_a.size(), 1);
        if (wa_a.size() == 1) begin
            check("s5_a0", wa_a[0], 16'h4000);
            check("s5_d0", wd_a[0], 16'h1234);
        end
        check("s5_odd",  err_odd_a, 1);
        check("s5_wcnt", word_count_a, 1);

        // odd byte on the origin high half
        clear_log();
        pulse_start();
        check("s5b_odd_clr", err_odd_a, 0);
        send_image(img6, 0);
        check("s5b_done",   load_done_a, 1);
        check("s5b_odd",    err_odd_a, 1);
        check("s5b_origin", origin_a, 0);

        // 6: reset on the edge accepting the second data word's low byte
        clear_log();
        pulse_start();
        send_byte(8'h30, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'hE0, 0, 0);
        send_byte(8'h02, 0, 0);
        send_byte(8'hF0, 0, 0);
        s_data = 8'h25; s_valid = 1'b1; s_last = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        check("s6_we",       mem_we_a, 0);
        check("s6_addr",     mem_addr_a, 0);
        check("s6_wdata",    mem_wdata_a, 0);
        check("s6_hold",     cpu_hold_a, 0);
        check("s6_ready",    s_ready_a, 0);
        check("s6_origin",   origin_a, 0);
        check("s6_wcnt",     word_count_a, 0);
        check("s6_done",     load_done_a, 0);
        tick();
        check("s6_nwr", wa_a.size(), 1);
        clear_log();
        pulse_start();
        send_image(img1, 0);
        tick();
        check_scen1("s6r");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lc3_program_loader.md
# lc3_program_loader

Write-side companion to the LC-3 instruction memory. Accepts an LC-3 object image as a byte stream (big-endian 16-bit words; first word is the origin) and writes each following word into instruction RAM at consecutive addresses from the origin. Holds the CPU off the instruction memory while a load is in progress. Sits between the host/UART byte source and the instruction RAM write port.

## Interface

- ADDR_W, 16: instruction RAM address width in bits (depth 2^ADDR_W words, 1..16).

- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse. Begins a load when the FSM is in IDLE or DONE.
- s_data  in  8  stream byte.
- s_valid  in  1  byte valid.
- s_last  in  1  final byte of the image; qualified by s_valid.
- s_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction RAM write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address; low ADDR_W bits of the 16-bit word address.
- mem_wdata  out  16  write data.
- cpu_hold  out  1  high while a load is in progress.
- load_done  out  1  sticky; high in DONE.
- origin  out  16  origin word of the current or last image.
- word_count  out  16  data words consumed, excluding the origin word; wraps mod 2^16.
- err_overflow  out  1  sticky; at least one word addressed at or above 2^ADDR_W.
- err_odd  out  1  sticky; s_last arrived on a high byte.

## Operation

- A byte is accepted on any rising edge where s_valid and s_ready are both high. s_data and s_last are sampled on that edge.
- States and behaviour:
  - IDLE: reset state; s_ready=0. start moves to ORG_HI.
  - ORG_HI: s_ready=1. An accept latches the high byte and moves to ORG_LO.
  - ORG_LO: s_ready=1. An accept sets origin={hi,lo}, loads the address counter with origin, and moves to DAT_HI. If s_last is set, moves to DONE instead, with word_count=0.
  - DAT_HI: s_ready=1. An accept latches the high byte and moves to DAT_LO.
  - DAT_LO: s_ready=1. An accept forms the word {hi,lo}, issues a write, increments the address counter and word_count, and moves to DAT_HI. If s_last is set, moves to DONE instead.
  - DONE: s_ready=0. start moves to ORG_HI.
- start is ignored in ORG_HI, ORG_LO, DAT_HI and DAT_LO.
- On start:
  - origin, word_count, err_overflow, err_odd and load_done clear.
  - cpu_hold goes high.
- Address counter:
  - 16 bits wide; wraps 0xFFFF -> 0x0000 with no error.
  - If bits [15:ADDR_W] are nonzero, the word is consumed and counted but not written (mem_we stays low), and err_overflow is set.
  - With ADDR_W=16 no word is ever out of range.
- s_last on a high-byte accept (ORG_HI or DAT_HI):
  - The byte is discarded, err_odd is set, and the FSM moves to DONE.
  - In ORG_HI, origin stays 0.
- s_last with s_valid low has no effect.
- cpu_hold=1 in ORG_HI, ORG_LO, DAT_HI and DAT_LO; 0 in IDLE and DONE.

## Timing

- Reset values:
  - FSM in IDLE.
  - s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=0, load_done=0.
  - origin=0, word_count=0.
  - err_overflow=0, err_odd=0.
- All outputs are registered, and s_ready is a decode of the registered state; there is no combinational path from s_valid to s_ready.
- start on edge N: s_ready=1 and cpu_hold=1 from cycle N+1.
- Write latency is one cycle. A DAT_LO accept on edge N gives mem_we=1 with the word's mem_addr and mem_wdata during cycle N+1 only. word_count also updates in cycle N+1.
- Sustained rate is one byte per cycle, so at most one write every two cycles.
- Final accept on edge N (any s_last, or the odd-byte case): from cycle N+1, load_done=1, cpu_hold=0 and s_ready=0. The final mem_we, if any, falls in the same cycle N+1.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Gaps in s_valid stall the FSM indefinitely with no timeout.
- Reset mid-load: outputs take their reset values on the next edge. A write scheduled for that cycle is suppressed. cpu_hold drops.
- start and reset in the same cycle: reset wins.

## Test plan

- ADDR_W=16; start; bytes 30 00 E0 02 F0 25 (s_last on 25) at one byte per cycle -> writes 0x3000<=0xE002 and 0x3001<=0xF025; origin=0x3000; word_count=2; load_done=1 and cpu_hold=0 in the cycle after 25.
- Same image with s_valid low for 3 cycles between every byte -> identical writes; exactly 2 mem_we pulses; no byte dropped or duplicated.
- Origin 0xFFFF, words 0x1111 then 0x2222 (last) -> writes at 0xFFFF then 0x0000; err_overflow=0.
- ADDR_W=10; origin 0x03FF, words 0xAAAA then 0xBBBB (last) -> one write, 0x3FF<=0xAAAA; second word not written; err_overflow=1; word_count=2.
- Bytes 40 00 12 34 56 with s_last on 56 -> write 0x4000<=0x1234; err_odd=1; load_done=1; no second write.
- reset asserted on the edge that accepts the low byte of the second data word -> no mem_we the following cycle; all outputs at reset values; a following start plus the full image from scenario 1 loads correctly.
